// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter with locked tenures and one TURN bubble between grants.
// Optional RR_TIMEOUT_EN forces release after MAX_HOLD cycles and pulses o_preempt.
`default_nettype none

module rr_lock_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_release,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_gnt_valid,
  output logic [IDW-1:0]     o_gnt_id,
  output logic [IDW-1:0]     o_pri_ptr,
  output logic               o_preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic               r_gnt_valid, w_valid_nxt;
  logic [IDW-1:0]     r_gnt_id, w_id_nxt;
  logic [IDW-1:0]     r_ptr, w_ptr_nxt;
  logic               r_preempt, w_preempt_nxt;

  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [IDW-1:0]     w_idx;
  logic               w_rel;
  logic               w_drop;
  logic               w_timeout;
  logic               w_end;

  // Circular scan starting at r_ptr; NUM_REQ is a power of two so index wrap is free.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = r_ptr + IDW'(i);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_rel  = i_release[r_gnt_id];
  assign w_drop = ~i_req[r_gnt_id];
  assign w_end  = (r_state == GRANT) && (w_rel || w_drop || w_timeout);

`ifdef RR_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] c_HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] r_hold_cnt, w_hold_nxt;

  assign w_timeout = (r_hold_cnt == c_HOLD_LAST);

  always_comb begin
    w_hold_nxt = '0;
    if (r_state == GRANT && !w_end)
      w_hold_nxt = (r_hold_cnt == c_HOLD_LAST) ? r_hold_cnt : r_hold_cnt + 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_hold_cnt <= '0;
    else         r_hold_cnt <= w_hold_nxt;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_valid_nxt   = r_gnt_valid;
    w_id_nxt      = r_gnt_id;
    w_ptr_nxt     = r_ptr;
    w_preempt_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en && w_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
          w_valid_nxt = 1'b1;
          w_id_nxt    = w_win;
        end else begin
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_id_nxt    = '0;
        end
      end
      GRANT: begin
        if (w_end) begin
          w_state_nxt   = TURN;
          w_gnt_nxt     = '0;
          w_valid_nxt   = 1'b0;
          w_id_nxt      = '0;
          w_ptr_nxt     = r_gnt_id + 1'b1;
          // A real release or request drop in the timeout cycle wins over preemption.
          w_preempt_nxt = w_timeout && !w_rel && !w_drop;
        end
      end
      TURN: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_id_nxt    = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_id_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_ptr       <= '0;
      r_preempt   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= w_valid_nxt;
      r_gnt_id    <= w_id_nxt;
      r_ptr       <= w_ptr_nxt;
      r_preempt   <= w_preempt_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_id    = r_gnt_id;
  assign o_pri_ptr   = r_ptr;
  assign o_preempt   = r_preempt;

endmodule

`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
// Directed vector bench for rr_lock_arbiter (NUM_REQ=4, MAX_HOLD=8).
`default_nettype none

module tb_rr_lock_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] rel;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [1:0] pri_ptr;
  logic       preempt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_lock_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_en       (en),
    .i_req      (req),
    .i_release  (rel),
    .o_gnt      (gnt),
    .o_gnt_valid(gnt_valid),
    .o_gnt_id   (gnt_id),
    .o_pri_ptr  (pri_ptr),
    .o_preempt  (preempt)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic [1:0] id;
    logic [1:0] ptr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic e, logic [3:0] q, logic [3:0] l,
                              logic [3:0] g, logic [1:0] i, logic [1:0] p);
    vec_t v;
    v.rst = r; v.en = e; v.req = q; v.rel = l; v.gnt = g; v.id = i; v.ptr = p;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [3:0] q, input logic [3:0] l);
    rst = r; en = e; req = q; rel = l;
  endtask

  int run;
  int pre_cnt;
  logic [1:0] ptr_at_end;
  logic pre_at_end;

  initial begin
    drive(1'b1, 1'b0, 4'b0000, 4'b0000);
    //        rst en  req      rel      gnt      id    ptr
    tv.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0)); // reset
    tv.push_back(mk(0, 1, 4'b0110, 4'b0000, 4'b0010, 2'd1, 2'd0)); // grant 1
    tv.push_back(mk(0, 1, 4'b0110, 4'b0000, 4'b0010, 2'd1, 2'd0));
    tv.push_back(mk(0, 1, 4'b0110, 4'b0100, 4'b0010, 2'd1, 2'd0)); // non-owner release ignored
    tv.push_back(mk(0, 1, 4'b0110, 4'b0010, 4'b0000, 2'd0, 2'd2)); // TURN
    tv.push_back(mk(0, 1, 4'b0110, 4'b0000, 4'b0000, 2'd0, 2'd2)); // IDLE
    tv.push_back(mk(0, 1, 4'b0110, 4'b0000, 4'b0100, 2'd2, 2'd2)); // grant 2
    tv.push_back(mk(0, 1, 4'b0010, 4'b0000, 4'b0000, 2'd0, 2'd3)); // owner drops req
    tv.push_back(mk(0, 1, 4'b0010, 4'b0000, 4'b0000, 2'd0, 2'd3));
    tv.push_back(mk(0, 1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 2'd3)); // scan 3,0,1
    tv.push_back(mk(0, 1, 4'b0010, 4'b0010, 4'b0000, 2'd0, 2'd2));
    tv.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd2));
    tv.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd2)); // idle, ptr stays
    tv.push_back(mk(0, 1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 2'd2)); // fairness
    tv.push_back(mk(0, 1, 4'b1111, 4'b0100, 4'b0000, 2'd0, 2'd3));
    tv.push_back(mk(0, 1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 2'd3));
    tv.push_back(mk(0, 1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 2'd3));
    tv.push_back(mk(0, 1, 4'b1111, 4'b1000, 4'b0000, 2'd0, 2'd0)); // wrap 3 -> 0
    tv.push_back(mk(0, 1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 2'd0));
    tv.push_back(mk(0, 1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 2'd0));
    tv.push_back(mk(0, 1, 4'b1111, 4'b0001, 4'b0000, 2'd0, 2'd1));
    tv.push_back(mk(0, 1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 2'd1));
    tv.push_back(mk(0, 1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 2'd1));
    tv.push_back(mk(0, 1, 4'b1111, 4'b0010, 4'b0000, 2'd0, 2'd2));
    tv.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b0000, 2'd0, 2'd2)); // en low
    tv.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b0000, 2'd0, 2'd2));
    tv.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b0000, 2'd0, 2'd2));
    tv.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 2'd2));
    tv.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 2'd2)); // en drop keeps grant
    tv.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 2'd2));
    tv.push_back(mk(0, 0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 2'd1));
    tv.push_back(mk(0, 1, 4'b1000, 4'b0000, 4'b0000, 2'd0, 2'd1));
    tv.push_back(mk(0, 1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 2'd1));
    tv.push_back(mk(1, 1, 4'b1000, 4'b0000, 4'b0000, 2'd0, 2'd0)); // reset mid-tenure
    tv.push_back(mk(0, 1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 2'd0)); // straight from IDLE

    for (int k = 0; k < tv.size(); k++) begin
      drive(tv[k].rst, tv[k].en, tv[k].req, tv[k].rel);
      tick();
      check("gnt",       k, 32'(gnt),       32'(tv[k].gnt));
      check("gnt_id",    k, 32'(gnt_id),    32'(tv[k].id));
      check("gnt_valid", k, 32'(gnt_valid), 32'(|tv[k].gnt));
      check("pri_ptr",   k, 32'(pri_ptr),   32'(tv[k].ptr));
      check("preempt",   k, 32'(preempt),   32'd0);
    end

    // Owner 3 releases, then requester 2 holds forever.
    drive(1'b0, 1'b1, 4'b1000, 4'b1000);
    tick();
    check("rel3_ptr", 0, 32'(pri_ptr), 32'd0);
    drive(1'b0, 1'b1, 4'b0100, 4'b0000);
    tick();
    tick();
    check("hold_gnt", 0, 32'(gnt), 32'b0100);
    run = 1;
    pre_cnt = 0;
    pre_at_end = 1'b0;
    ptr_at_end = 2'd0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (preempt) pre_cnt++;
      if (gnt[2]) begin
        run++;
      end else begin
        pre_at_end = preempt;
        ptr_at_end = pri_ptr;
        break;
      end
    end
`ifdef RR_TIMEOUT_EN
    check("hold_len",     0, 32'(run),        32'd8);
    check("preempt_end",  0, 32'(pre_at_end), 32'd1);
    check("preempt_ptr",  0, 32'(ptr_at_end), 32'd3);
    tick();
    check("preempt_once", 0, 32'(preempt),    32'd0);
`else
    check("hold_len_50",  0, 32'(run >= 50),  32'd1);
    check("preempt_none", 0, 32'(pre_cnt),    32'd0);
    check("hold_ptr",     0, 32'(pri_ptr),    32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
